// File: rtl/multicycle_controller_pkg.sv
//------------------------------------------------------------------------------
// Module      : multicycle_controller_pkg
// Description : Shared types, codes and decode helpers for the multicycle
//               RISC-V control unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [1:0] c_IMM_I = 2'b00;
    localparam logic [1:0] c_IMM_S = 2'b01;
    localparam logic [1:0] c_IMM_B = 2'b10;
    localparam logic [1:0] c_IMM_J = 2'b11;

    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_DATA   = 2'b01;
    localparam logic [1:0] c_RES_ALURES = 2'b10;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_REG   = 2'b10;

    localparam logic [1:0] c_SRCB_REG  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
    } ctrl_t;

    // Moore output table; anything not set in a state stays zero.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_b  = c_SRCB_FOUR;
                c.result_src = c_RES_ALURES;
                c.pc_update  = 1'b1;
                c.alu_op     = c_ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_a = c_SRCA_OLDPC;
                c.alu_src_b = c_SRCB_IMM;
                c.alu_op    = c_ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = c_SRCA_REG;
                c.alu_src_b = c_SRCB_IMM;
                c.alu_op    = c_ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = c_RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = c_RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = c_SRCA_REG;
                c.alu_src_b = c_SRCB_REG;
                c.alu_op    = c_ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = c_SRCA_REG;
                c.alu_src_b = c_SRCB_IMM;
                c.alu_op    = c_ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = c_RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = c_SRCA_REG;
                c.alu_src_b = c_SRCB_REG;
                c.alu_op    = c_ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = c_SRCA_OLDPC;
                c.alu_src_b = c_SRCB_FOUR;
                c.alu_op    = c_ALUOP_ADD;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            c_OP_STORE:  return c_IMM_S;
            c_OP_BRANCH: return c_IMM_B;
            c_OP_JAL:    return c_IMM_J;
            default:     return c_IMM_I;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
//------------------------------------------------------------------------------
// Module      : alu_decoder
// Description : Combinational ALUOp/funct3/funct7 to ALUControl decode.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op_b5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    logic w_rtype_sub;

    // Only register-register ops carry a subtract in funct7; addi never does.
    assign w_rtype_sub = i_op_b5 & i_funct7b5;

    always_comb begin
        o_alu_control = c_ALU_ADD;
        case (i_alu_op)
            c_ALUOP_ADD: o_alu_control = c_ALU_ADD;
            c_ALUOP_SUB: o_alu_control = c_ALU_SUB;
            c_ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = w_rtype_sub ? c_ALU_SUB : c_ALU_ADD;
                    3'b010:  o_alu_control = c_ALU_SLT;
                    3'b110:  o_alu_control = c_ALU_OR;
                    3'b111:  o_alu_control = c_ALU_AND;
                    default: o_alu_control = c_ALU_ADD;
                endcase
            end
            default: o_alu_control = c_ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
//------------------------------------------------------------------------------
// Module      : multicycle_controller
// Description : Moore FSM control unit for a multicycle RV32I subset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] state_dbg
);

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
                    c_OP_RTYPE:            w_next = S_EXECUTER;
                    c_OP_ITYPE:            w_next = S_EXECUTEI;
                    c_OP_BRANCH:           w_next = S_BEQ;
                    c_OP_JAL:              w_next = S_JAL;
                    default:               w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI,
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next);
        end
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (r_ctrl.alu_op),
        .i_funct3      (funct3),
        .i_op_b5       (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

    assign PCWrite   = r_ctrl.pc_update | (r_ctrl.branch & Zero);
    assign AdrSrc    = r_ctrl.adr_src;
    assign MemWrite  = r_ctrl.mem_write;
    assign IRWrite   = r_ctrl.ir_write;
    assign ResultSrc = r_ctrl.result_src;
    assign ALUSrcA   = r_ctrl.alu_src_a;
    assign ALUSrcB   = r_ctrl.alu_src_b;
    assign RegWrite  = r_ctrl.reg_write;
    assign ImmSrc    = imm_src_for(op);
    assign state_dbg = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_controller
// Description : Scoreboard bench for multicycle_controller with directed vectors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_controller;

    localparam int D = -1;

    typedef struct {
        string tag;
        int    st;
        int    irw;
        int    pcw;
        int    mw;
        int    rw;
        int    adr;
        int    res;
        int    alc;
        int    imm;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [3:0] state_dbg;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input int act, input int exp);
        if (exp >= 0) begin
            n_total++;
            if (act == exp) n_pass++;
            else $display("FAIL %s.%s: got %0d expected %0d", tag, field, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a state, compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "state",  int'(state_dbg),  e.st);
            chk(e.tag, "IRWrite", int'(IRWrite),   e.irw);
            chk(e.tag, "PCWrite", int'(PCWrite),   e.pcw);
            chk(e.tag, "MemWrite", int'(MemWrite), e.mw);
            chk(e.tag, "RegWrite", int'(RegWrite), e.rw);
            chk(e.tag, "AdrSrc", int'(AdrSrc),     e.adr);
            chk(e.tag, "ResultSrc", int'(ResultSrc), e.res);
            chk(e.tag, "ALUControl", int'(ALUControl), e.alc);
            chk(e.tag, "ImmSrc", int'(ImmSrc),     e.imm);
        end
    end

    task automatic push(input string tag, input int st, input int irw, input int pcw,
                        input int mw, input int rw, input int adr, input int res,
                        input int alc, input int imm);
        exp_t e;
        e.tag = tag; e.st = st; e.irw = irw; e.pcw = pcw; e.mw = mw; e.rw = rw;
        e.adr = adr; e.res = res; e.alc = alc; e.imm = imm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enter FETCH and present the next instruction's fields during that cycle.
    task automatic fetch(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        step();
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        push("fetch", 0, 1, 1, 0, 0, 0, 2, 0, D);
    endtask

    initial begin
        rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; Zero = 1'b0;

        repeat (3) begin
            step();
            push("reset", 0, 1, 1, 0, 0, D, D, D, D);
        end
        @(negedge clk); #1 rst_n = 1'b1;

        // sub
        step(); push("sub_dec", 1, 0, 0, 0, 0, D, D, 0, 0);
        step(); push("sub_exe", 6, 0, 0, 0, 0, D, D, 1, D);
        step(); push("sub_wb",  8, 0, 0, 0, 1, D, 0, D, D);
        // addi with funct7b5 set must still add
        fetch(7'b0010011, 3'b000, 1'b1, 1'b0);
        step(); push("addi_dec", 1, 0, 0, 0, 0, D, D, 0, 0);
        step(); push("addi_exe", 7, 0, 0, 0, 0, D, D, 0, 0);
        step(); push("addi_wb",  8, 0, 0, 0, 1, D, 0, D, D);
        // or
        fetch(7'b0110011, 3'b110, 1'b0, 1'b0);
        step(); push("or_dec", 1, 0, 0, 0, 0, D, D, 0, D);
        step(); push("or_exe", 6, 0, 0, 0, 0, D, D, 3, D);
        step(); push("or_wb",  8, 0, 0, 0, 1, D, 0, D, D);
        // slti
        fetch(7'b0010011, 3'b010, 1'b0, 1'b0);
        step(); push("slti_dec", 1, 0, 0, 0, 0, D, D, 0, D);
        step(); push("slti_exe", 7, 0, 0, 0, 0, D, D, 5, D);
        step(); push("slti_wb",  8, 0, 0, 0, 1, D, 0, D, D);
        // and
        fetch(7'b0110011, 3'b111, 1'b0, 1'b0);
        step(); push("and_dec", 1, 0, 0, 0, 0, D, D, 0, D);
        step(); push("and_exe", 6, 0, 0, 0, 0, D, D, 2, D);
        step(); push("and_wb",  8, 0, 0, 0, 1, D, 0, D, D);
        // lw
        fetch(7'b0000011, 3'b010, 1'b0, 1'b0);
        step(); push("lw_dec",  1, 0, 0, 0, 0, D, D, 0, 0);
        step(); push("lw_adr",  2, 0, 0, 0, 0, 0, D, 0, 0);
        step(); push("lw_read", 3, 0, 0, 0, 0, 1, 0, D, D);
        step(); push("lw_wb",   4, 0, 0, 0, 1, 0, 1, D, D);
        // sw
        fetch(7'b0100011, 3'b010, 1'b0, 1'b0);
        step(); push("sw_dec", 1, 0, 0, 0, 0, D, D, 0, 1);
        step(); push("sw_adr", 2, 0, 0, 0, 0, 0, D, 0, 1);
        step(); push("sw_wr",  5, 0, 0, 1, 0, 1, D, D, 1);
        // beq taken
        fetch(7'b1100011, 3'b000, 1'b0, 1'b1);
        step(); push("beq1_dec", 1, 0, 0, 0, 0, D, D, 0, 2);
        step(); push("beq1_br",  9, 0, 1, 0, 0, D, D, 1, 2);
        // bne encoding still uses the beq path; not taken here
        fetch(7'b1100011, 3'b001, 1'b0, 1'b0);
        step(); push("beq0_dec", 1, 0, 0, 0, 0, D, D, 0, 2);
        step(); push("beq0_br",  9, 0, 0, 0, 0, D, D, 1, 2);
        // jal
        fetch(7'b1101111, 3'b000, 1'b0, 1'b0);
        step(); push("jal_dec", 1, 0, 0, 0, 0, D, D, 0, 3);
        step(); push("jal_jmp", 10, 0, 1, 0, 0, D, D, 0, 3);
        step(); push("jal_wb",  8, 0, 0, 0, 1, D, 0, D, 3);
        // illegal
        fetch(7'b1111111, 3'b000, 1'b1, 1'b0);
        step(); push("ill_dec", 1, 0, 0, 0, 0, D, D, 0, 0);
        // sw aborted by asynchronous reset during MEMWRITE
        fetch(7'b0100011, 3'b000, 1'b0, 1'b0);
        step(); push("swr_dec", 1, 0, 0, 0, 0, D, D, D, 1);
        step(); push("swr_adr", 2, 0, 0, 0, 0, D, D, D, 1);
        step(); #1 rst_n = 1'b0;
        push("swr_abort", 0, 1, 1, 0, 0, D, D, D, D);
        @(negedge clk); #1 rst_n = 1'b1;
        op = 7'b0110011;
        step(); push("post_rst", 1, 0, 0, 0, 0, D, D, 0, D);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
